// File: rtl/fft_pkg.sv
// Shared constants and index type for the 8-point inverse-FFT twiddle stage.
package fft_pkg;

  localparam int unsigned C256  = 32'd256;
  localparam int unsigned C181  = 32'd181;
  localparam int unsigned ROUND = 32'd128;

  typedef logic [2:0] tw_idx_t;

endpackage

// File: rtl/ifac8_lane.sv
// Single-lane conjugate twiddle multiply; purely combinational, full-precision products.
module ifac8_lane
  import fft_pkg::*;
#(
  parameter int I_WIDTH   = 11,
  parameter int FAC_WIDTH = 21
) (
  input  logic signed [I_WIDTH-1:0]   a,
  input  logic signed [I_WIDTH-1:0]   b,
  input  tw_idx_t                     sel,
  output logic signed [FAC_WIDTH-1:0] re,
  output logic signed [FAC_WIDTH-1:0] im
);

  logic signed [FAC_WIDTH-1:0] a_x_s;
  logic signed [FAC_WIDTH-1:0] b_x_s;
  logic signed [FAC_WIDTH-1:0] k256_s;
  logic signed [FAC_WIDTH-1:0] k181_s;
  logic signed [FAC_WIDTH-1:0] a256_s;
  logic signed [FAC_WIDTH-1:0] b256_s;
  logic signed [FAC_WIDTH-1:0] a181_s;
  logic signed [FAC_WIDTH-1:0] b181_s;

  // Sign-extend before multiplying so the products carry full precision.
  assign a_x_s  = FAC_WIDTH'(a);
  assign b_x_s  = FAC_WIDTH'(b);
  assign k256_s = FAC_WIDTH'(C256);
  assign k181_s = FAC_WIDTH'(C181);
  assign a256_s = a_x_s * k256_s;
  assign b256_s = b_x_s * k256_s;
  assign a181_s = a_x_s * k181_s;
  assign b181_s = b_x_s * k181_s;

  // Select the conjugate factor combination for this twiddle index.
  always_comb begin
    re = a256_s;
    im = b256_s;
    case (sel)
      3'd3: begin
        re = -b256_s;
        im = a256_s;
      end
      3'd5: begin
        re = a181_s - b181_s;
        im = a181_s + b181_s;
      end
      3'd7: begin
        re = -a181_s - b181_s;
        im = a181_s - b181_s;
      end
      default: begin
        re = a256_s;
        im = b256_s;
      end
    endcase
  end

endmodule

// File: rtl/ifac8_1_seq.sv
// Two-stage inverse-FFT twiddle pipeline: index counter, lane products, rounding.
module ifac8_1_seq
  import fft_pkg::*;
#(
  parameter int I_WIDTH    = 11,
  parameter int FAC_WIDTH  = 21,
  parameter int O_WIDTH    = 13,
  parameter int DATA_WIDTH = 16,
  parameter int SHIFT      = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                din_valid,
  input  logic                                frame_start,
  input  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]  din_re,
  input  logic [DATA_WIDTH-1:0][I_WIDTH-1:0]  din_im,
  output logic                                dout_valid,
  output logic [DATA_WIDTH-1:0][O_WIDTH-1:0]  dout_re,
  output logic [DATA_WIDTH-1:0][O_WIDTH-1:0]  dout_im,
  output logic [2:0]                          dout_sel
);

  tw_idx_t cnt_q, cnt_d;
  tw_idx_t sel_s;

  logic    v1_q, v1_d;
  tw_idx_t sel1_q, sel1_d;
  logic [DATA_WIDTH-1:0][FAC_WIDTH-1:0] prod_re_q, prod_re_d;
  logic [DATA_WIDTH-1:0][FAC_WIDTH-1:0] prod_im_q, prod_im_d;
  logic [DATA_WIDTH-1:0][FAC_WIDTH-1:0] lane_re_s, lane_im_s;

  logic    v2_q, v2_d;
  tw_idx_t sel2_q, sel2_d;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0] out_re_q, out_re_d;
  logic [DATA_WIDTH-1:0][O_WIDTH-1:0] out_im_q, out_im_d;

  // Round half up, arithmetic shift, then keep the low O_WIDTH bits (range is guaranteed).
  function automatic logic [O_WIDTH-1:0] round_fn(input logic signed [FAC_WIDTH-1:0] p);
    logic signed [FAC_WIDTH-1:0] rnd;
    logic signed [FAC_WIDTH-1:0] s;
    rnd = FAC_WIDTH'(ROUND);
    s   = p + rnd;
    s   = s >>> SHIFT;
    return s[O_WIDTH-1:0];
  endfunction

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    ifac8_lane #(
      .I_WIDTH  (I_WIDTH),
      .FAC_WIDTH(FAC_WIDTH)
    ) u_lane (
      .a  ($signed(din_re[g])),
      .b  ($signed(din_im[g])),
      .sel(sel_s),
      .re (lane_re_s[g]),
      .im (lane_im_s[g])
    );
  end

  // Twiddle index: frame_start forces index 0 and restarts the count at 1.
  always_comb begin
    cnt_d = cnt_q;
    sel_s = cnt_q;
    if (din_valid) begin
      if (frame_start) begin
        sel_s = 3'd0;
        cnt_d = 3'd1;
      end else begin
        sel_s = cnt_q;
        cnt_d = cnt_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline next-state; data registers hold across bubbles so outputs stay stable.
  always_comb begin
    v1_d      = din_valid;
    sel1_d    = sel1_q;
    prod_re_d = prod_re_q;
    prod_im_d = prod_im_q;
    v2_d      = v1_q;
    sel2_d    = sel2_q;
    out_re_d  = out_re_q;
    out_im_d  = out_im_q;
    if (din_valid) begin
      sel1_d    = sel_s;
      prod_re_d = lane_re_s;
      prod_im_d = lane_im_s;
    end else begin
      sel1_d    = sel1_q;
    end
    if (v1_q) begin
      sel2_d = sel1_q;
      for (int l = 0; l < DATA_WIDTH; l++) begin
        out_re_d[l] = round_fn(prod_re_q[l]);
        out_im_d[l] = round_fn(prod_im_q[l]);
      end
    end else begin
      sel2_d = sel2_q;
    end
  end

  // State registers; reset drops in-flight beats and clears all outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= 3'd0;
      v1_q      <= 1'b0;
      sel1_q    <= 3'd0;
      prod_re_q <= '0;
      prod_im_q <= '0;
      v2_q      <= 1'b0;
      sel2_q    <= 3'd0;
      out_re_q  <= '0;
      out_im_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      v1_q      <= v1_d;
      sel1_q    <= sel1_d;
      prod_re_q <= prod_re_d;
      prod_im_q <= prod_im_d;
      v2_q      <= v2_d;
      sel2_q    <= sel2_d;
      out_re_q  <= out_re_d;
      out_im_q  <= out_im_d;
    end
  end

  assign dout_valid = v2_q;
  assign dout_sel   = sel2_q;
  assign dout_re    = out_re_q;
  assign dout_im    = out_im_q;

endmodule
